addr_bus_arbiter: RTL

ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

---
 rtl/addr_arb_pkg.sv | 34 +++
 rtl/addr_bus_arbiter_rr_pick.sv | 27 ++
 rtl/addr_bus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/addr_arb_pkg.sv
// Shared definitions for the six-requester address bus arbiter.
package addr_arb_pkg;

  localparam int unsigned N_REQ = 6;

  localparam logic [2:0] FFT_READ  = 3'd0;
  localparam logic [2:0] FFT_WRITE = 3'd1;
  localparam logic [2:0] FIR_READ  = 3'd2;
  localparam logic [2:0] FIR_WRITE = 3'd3;
  localparam logic [2:0] IIR_READ  = 3'd4;
  localparam logic [2:0] IIR_WRITE = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // One-hot decode of a requester index; indices 6 and 7 decode to zero.
  function automatic logic [N_REQ-1:0] onehot6(input logic [2:0] i);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      r[k] = (i == 3'(k));
    end
    return r;
  endfunction

  // Next requester index with wrap from 5 back to 0.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i >= 3'(N_REQ - 1)) ? 3'd0 : i + 3'd1;
  endfunction

endpackage

// File: rtl/addr_bus_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index at or after start.
module rr_pick
  import addr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic [2:0]       start,
  output logic             found,
  output logic [2:0]       idx
);

  logic [2:0] pos;

  // Walk all six positions from start, keeping the first eligible hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = (start >= 3'(N_REQ)) ? 3'd0 : start;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && ((eligible & onehot6(pos)) != '0)) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = next_idx(pos);
    end
  end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter sharing one address bus among six address calculators,
// with a bounded burst length when other requesters are waiting.
module addr_bus_arbiter
  import addr_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        done,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        pause,
  output logic [N_REQ-1:0]        grant,
  output logic [2:0]              owner,
  output logic [ADDR_W-1:0]       addr,
  output logic                    addr_valid,
  output logic                    busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  arb_state_t       state, state_n;
  logic [2:0]       owner_n, last_owner, last_owner_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] elig, owner_mask, grant_n;
  logic             owner_elig, other_elig;
  logic [2:0]       search_base, pick_idx;
  logic             pick_found;
  logic [ADDR_W-1:0] sel_addr;

  assign elig       = req & ~done;
  assign owner_mask = onehot6(owner);
  assign owner_elig = |(elig & owner_mask);
  assign other_elig = |(elig & ~owner_mask);

  // During TURN the outgoing owner becomes the new last_owner on this same
  // edge, so the search already starts just after it.
  assign search_base = (state == TURN) ? owner : last_owner;

  rr_pick u_rr_pick (
    .eligible (elig),
    .start    (next_idx(search_base)),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Address slice of the current owner.
  always_comb begin
    sel_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (owner == 3'(k)) sel_addr = addr_in[k*ADDR_W +: ADDR_W];
    end
  end

  // Next-state, owner selection and burst counter.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    cnt_n        = cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          owner_n = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!owner_elig || (cnt == CNT_MAX && other_elig)) begin
          state_n = TURN;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TURN: begin
        last_owner_n = owner;
        cnt_n        = '0;
        if (pick_found) begin
          state_n = GRANT;
          owner_n = pick_idx;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign grant_n = (state_n == GRANT) ? onehot6(owner_n) : '0;

  // State, owner bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= 3'd5;
      cnt        <= '0;
      grant      <= '0;
      pause      <= '1;
      busy       <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      pause      <= ~grant_n;
      busy       <= (state_n != IDLE);
      if (state == GRANT) begin
        addr       <= sel_addr;
        addr_valid <= 1'b1;
      end else begin
        addr_valid <= 1'b0;
      end
    end
  end

endmodule
